// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier: one add/sub-and-shift step per clock,
// W steps per product, with the add/subtract delegated to a carry-lookahead adder.

module addsub_cla #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         m,
  output logic [N-1:0] s,
  output logic         c,
  output logic         v
);
  logic [N-1:0] bx;
  logic [N-1:0] g;
  logic [N-1:0] pr;
  logic [N:0]   cy;

  // m=1 turns the add into a - b via inverted b and carry-in of 1
  always_comb begin
    bx = b ^ {N{m}};
    g  = a & bx;
    pr = a ^ bx;
    cy = '0;
    cy[0] = m;
    for (int i = 0; i < N; i++) begin
      cy[i+1] = g[i] | (pr[i] & cy[i]);
    end
    s = pr ^ cy[N-1:0];
    c = cy[N];
    v = cy[N] ^ cy[N-1];
  end
endmodule

module booth_mul_seq #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_nxt;

  logic signed [W:0] acc;
  logic signed [W:0] mc;
  logic signed [W:0] sum;
  logic signed [W:0] step;
  logic [W-1:0]      q;
  logic              q_1;
  logic [CW-1:0]     cnt;
  logic              last;
  logic              add_c;
  logic              add_v;
  logic              unused_flags;

  assign last = (cnt == CW'(1));

  addsub_cla #(.N(W + 1)) u_addsub (
    .a (acc),
    .b (mc),
    .m (q[0] & ~q_1),
    .s (sum),
    .c (add_c),
    .v (add_v)
  );

  // carry-out and overflow are not needed: W+1 bits hold every partial sum
  assign unused_flags = add_c ^ add_v;

  // Booth pairs 00/11 leave the accumulator untouched
  assign step = (q[0] ^ q_1) ? sum : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      mc   <= '0;
      q    <= '0;
      q_1  <= 1'b0;
      cnt  <= '0;
      p    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        acc <= '0;
        q   <= b;
        q_1 <= 1'b0;
        mc  <= {a[W-1], a};
        cnt <= CW'(W);
      end else if (state == CALC) begin
        // arithmetic shift right of {step, q, q_1}
        acc <= {step[W], step[W:1]};
        q   <= {step[0], q[W-1:1]};
        q_1 <= q[0];
        cnt <= cnt - 1'b1;
        if (last) begin
          p    <= {step, q[W-1:1]};
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: a W=4 instance for directed and exhaustive
// cases and a W=8 instance for a random sweep.

module tb_booth_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  p4;
  logic [15:0] p8;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int v_cnt4 = 0;
  int v_cnt8 = 0;
  int t0, v0;
  logic [15:0] q4[$];
  logic [15:0] q8[$];

  always #5 clk = ~clk;

  booth_mul_seq #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4)
  );

  booth_mul_seq #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy4 && dut4.add_v) v_cnt4 <= v_cnt4 + 1;
    if (busy8 && dut8.add_v) v_cnt8 <= v_cnt8 + 1;
  end

  task automatic go4(input int av, input int bv);
    @(negedge clk);
    a4 = 4'(av);
    b4 = 4'(bv);
    start4 = 1'b1;
    q4.push_back(16'(av * bv));
    @(negedge clk);
    start4 = 1'b0;
    t0 = cyc;
    v0 = v_cnt4;
  endtask

  task automatic go8(input int av, input int bv);
    @(negedge clk);
    a8 = 8'(av);
    b8 = 8'(bv);
    start8 = 1'b1;
    q8.push_back(16'(av * bv));
    @(negedge clk);
    start8 = 1'b0;
    t0 = cyc;
    v0 = v_cnt8;
  endtask

  task automatic wait4(output bit ok, output int dc);
    ok = 1'b0;
    dc = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (done4) begin ok = 1'b1; dc = cyc; end
    end
  endtask

  task automatic wait8(output bit ok, output int dc);
    ok = 1'b0;
    dc = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (done8) begin ok = 1'b1; dc = cyc; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (busy4 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy4); end
    tests++; if (done4 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done4); end
    tests++; if (p4 !== 8'h00) begin fails++; $display("FAIL reset_p4: got %h want 00", p4); end
    tests++; if (p8 !== 16'h0000) begin fails++; $display("FAIL reset_p8: got %h want 0000", p8); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] e;
    go4(3, 5);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (busy4 !== 1'b1 || done4 !== 1'b0) begin
        fails++; $display("FAIL basic_busy[%0d]: got busy=%b done=%b want busy=1 done=0", i, busy4, done4);
      end
      @(negedge clk);
    end
    tests++;
    if (done4 !== 1'b1 || busy4 !== 1'b0) begin
      fails++; $display("FAIL basic_done: got done=%b busy=%b want done=1 busy=0", done4, busy4);
    end
    e = q4.pop_front();
    tests++; if (p4 !== e[7:0]) begin fails++; $display("FAIL basic_p: got %h want %h", p4, e[7:0]); end
    @(negedge clk);
    tests++;
    if (done4 !== 1'b0 || p4 !== e[7:0]) begin
      fails++; $display("FAIL basic_hold: got done=%b p=%h want done=0 p=%h", done4, p4, e[7:0]);
    end
  endtask

  task automatic test_corners;
    int ca[4] = '{-8, -8, 7, 0};
    int cb[4] = '{-8, 7, -1, -5};
    logic [7:0] want[4] = '{8'h40, 8'hC8, 8'hF9, 8'h00};
    logic [15:0] e;
    bit ok;
    int dc;
    for (int k = 0; k < 4; k++) begin
      go4(ca[k], cb[k]);
      wait4(ok, dc);
      e = q4.pop_front();
      tests++;
      if (!ok) begin
        fails++; $display("FAIL corner_timeout[%0d]: got no done want done", k);
      end else begin
        tests++; if (p4 !== want[k]) begin fails++; $display("FAIL corner_p[%0d]: got %h want %h", k, p4, want[k]); end
        tests++; if (p4 !== e[7:0]) begin fails++; $display("FAIL corner_ref[%0d]: got %h want %h", k, p4, e[7:0]); end
        tests++; if (v_cnt4 - v0 !== 0) begin fails++; $display("FAIL corner_v[%0d]: got %0d overflows want 0", k, v_cnt4 - v0); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] e;
    bit ok;
    int dc;
    @(negedge clk);
    a4 = 4'd2; b4 = 4'd3; start4 = 1'b1;
    q4.push_back(16'(2 * 3));
    @(negedge clk);
    t0 = cyc;
    a4 = 4'(-3); b4 = 4'd4;
    q4.push_back(16'(-3 * 4));
    wait4(ok, dc);
    e = q4.pop_front();
    tests++;
    if (!ok) begin
      fails++; $display("FAIL b2b_timeout1: got no done want done");
    end else begin
      tests++; if (p4 !== 8'h06 || p4 !== e[7:0]) begin fails++; $display("FAIL b2b_p1: got %h want 06", p4); end
      tests++; if (dc - t0 !== 4) begin fails++; $display("FAIL b2b_lat1: got %0d want 4", dc - t0); end
    end
    @(negedge clk);
    t0 = cyc;
    tests++;
    if (busy4 !== 1'b1 || done4 !== 1'b0) begin
      fails++; $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy4, done4);
    end
    start4 = 1'b0;
    wait4(ok, dc);
    e = q4.pop_front();
    tests++;
    if (!ok) begin
      fails++; $display("FAIL b2b_timeout2: got no done want done");
    end else begin
      tests++; if (p4 !== 8'hF4 || p4 !== e[7:0]) begin fails++; $display("FAIL b2b_p2: got %h want f4", p4); end
      tests++; if (dc - t0 !== 4) begin fails++; $display("FAIL b2b_lat2: got %0d want 4", dc - t0); end
    end
  endtask

  task automatic test_ignored_start;
    logic [15:0] e;
    bit ok;
    int dc, nd;
    go4(-2, 3);
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait4(ok, dc);
    e = q4.pop_front();
    tests++;
    if (!ok) begin
      fails++; $display("FAIL ignore_timeout: got no done want done");
    end else begin
      tests++; if (p4 !== e[7:0]) begin fails++; $display("FAIL ignore_p: got %h want %h", p4, e[7:0]); end
      tests++; if (dc - t0 !== 4) begin fails++; $display("FAIL ignore_lat: got %0d want 4", dc - t0); end
    end
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4) nd++;
    end
    tests++; if (nd !== 0) begin fails++; $display("FAIL ignore_extra_done: got %0d want 0", nd); end
    tests++; if (p4 !== e[7:0]) begin fails++; $display("FAIL ignore_hold: got %h want %h", p4, e[7:0]); end
  endtask

  task automatic test_reset_abort;
    logic [15:0] e;
    bit ok;
    int dc, nd;
    go4(5, 5);
    q4.delete();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy4 !== 1'b0 || p4 !== 8'h00 || done4 !== 1'b0) begin
      fails++; $display("FAIL abort_state: got busy=%b done=%b p=%h want 0 0 00", busy4, done4, p4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4) nd++;
    end
    tests++; if (nd !== 0) begin fails++; $display("FAIL abort_done: got %0d dones want 0", nd); end
    go4(5, 5);
    wait4(ok, dc);
    e = q4.pop_front();
    tests++;
    if (!ok) begin
      fails++; $display("FAIL abort_timeout: got no done want done");
    end else begin
      tests++; if (p4 !== 8'h19 || p4 !== e[7:0]) begin fails++; $display("FAIL abort_p: got %h want 19", p4); end
    end
  endtask

  task automatic test_sweep4;
    logic [15:0] e;
    bit ok;
    int dc;
    for (int ai = -8; ai < 8; ai++) begin
      for (int bi = -8; bi < 8; bi++) begin
        go4(ai, bi);
        wait4(ok, dc);
        e = q4.pop_front();
        tests++;
        if (!ok) begin
          fails++; $display("FAIL sweep4_timeout %0d*%0d: got no done want done", ai, bi);
        end else begin
          if (p4 !== e[7:0] || dc - t0 !== 4 || v_cnt4 - v0 !== 0) begin
            fails++;
            $display("FAIL sweep4 %0d*%0d: got p=%h lat=%0d v=%0d want p=%h lat=4 v=0",
                     ai, bi, p4, dc - t0, v_cnt4 - v0, e[7:0]);
          end
        end
      end
    end
  endtask

  task automatic test_random8;
    logic [15:0] e;
    logic [7:0] ra, rb;
    bit ok;
    int dc;
    for (int k = 0; k < 150; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (k == 0) begin ra = 8'h80; rb = 8'h80; end
      if (k == 1) begin ra = 8'h7F; rb = 8'h80; end
      go8(int'($signed(ra)), int'($signed(rb)));
      wait8(ok, dc);
      e = q8.pop_front();
      tests++;
      if (!ok) begin
        fails++; $display("FAIL rand8_timeout %h*%h: got no done want done", ra, rb);
      end else begin
        if (p8 !== e || dc - t0 !== 8 || v_cnt8 - v0 !== 0) begin
          fails++;
          $display("FAIL rand8 %h*%h: got p=%h lat=%0d v=%0d want p=%h lat=8 v=0",
                   ra, rb, p8, dc - t0, v_cnt8 - v0, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_ignored_start();
    test_reset_abort();
    test_sweep4();
    test_random8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
